line_fetcher: RTL

//   Upstream feeder for the slice-processing controller. On start, reads DEPTH

---
 rtl/line_fetcher_if.sv | 23 ++
 rtl/line_fetcher.sv | 102 ++++++++++
 2 files changed

// File: rtl/line_fetcher_if.sv
// line_fetcher_if: memory read port and line output stream of line_fetcher
interface line_fetcher_if #(
    parameter int LINE_W = 25,
    parameter int ADDR_W = 6
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_rdata;
    logic [LINE_W-1:0] line_out;
    logic [ADDR_W-1:0] line_idx;
    logic              line_valid;
    logic              line_ready;

    modport master (
        output mem_rd, mem_addr, line_out, line_idx, line_valid,
        input  mem_rdata, line_ready
    );

    modport slave (
        input  mem_rd, mem_addr, line_out, line_idx, line_valid,
        output mem_rdata, line_ready
    );
endinterface

// File: rtl/line_fetcher.sv
// line_fetcher: streams DEPTH lines from a sync-read memory through a 2-entry prefetch FIFO
module line_fetcher #(
    parameter int LINE_W = 25,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 25
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    line_fetcher_if.master bus,
    output logic           busy_o,
    output logic           done_o
);
    localparam logic [ADDR_W:0] CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   sent_q, sent_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] iss_addr_q;
    logic [1:0]        count_q;
    logic [LINE_W-1:0] data0_q, data1_q;
    logic [ADDR_W-1:0] idx0_q, idx1_q;
    logic              pop;
    logic              issue;
    logic [1:0]        occ;

    // Handshake decode; a slot freed by this cycle's pop is reused at once so reads keep pace
    always_comb begin
        pop   = (count_q != 2'd0) & bus.line_ready;
        occ   = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue = (state_q == FETCH) && (rd_ptr_q < CNT) && (occ < 2'd2);
    end

    // Next-state: run control plus read and transfer counters
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, issue};
        sent_d   = sent_q + {{ADDR_W{1'b0}}, pop};
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = FETCH;
                    rd_ptr_d = '0;
                    sent_d   = '0;
                end
            end
            FETCH: state_d = (issue && rd_ptr_q == LAST) ? DRAIN : FETCH;
            DRAIN: state_d = (pop && sent_q == LAST) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            sent_q   <= sent_d;
        end
    end

    // Prefetch FIFO; entry 0 is the registered head, the returning read tags its issue address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            iss_addr_q <= '0;
            count_q    <= '0;
            data0_q    <= '0;
            idx0_q     <= '0;
            data1_q    <= '0;
            idx1_q     <= '0;
        end else begin
            inflight_q <= issue;
            count_q    <= occ;
            if (issue) iss_addr_q <= rd_ptr_q[ADDR_W-1:0];
            if ((pop && (count_q == 2'd2 || inflight_q)) || (inflight_q && count_q == 2'd0)) begin
                data0_q <= (pop && count_q == 2'd2) ? data1_q : bus.mem_rdata;
                idx0_q  <= (pop && count_q == 2'd2) ? idx1_q : iss_addr_q;
            end
            if (inflight_q && count_q == (pop ? 2'd2 : 2'd1)) begin
                data1_q <= bus.mem_rdata;
                idx1_q  <= iss_addr_q;
            end
        end
    end

    assign bus.mem_rd     = issue;
    assign bus.mem_addr   = issue ? rd_ptr_q[ADDR_W-1:0] : '0;
    assign bus.line_out   = data0_q;
    assign bus.line_idx   = idx0_q;
    assign bus.line_valid = (count_q != 2'd0);
    assign busy_o         = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o         = (state_q == DONE);
endmodule
